// File: rtl/axi_sys_bridge.sv
// Single-beat AXI3/AXI4 slave bridging one read or write at a time onto the
// sys_* register bus, with an ack timeout and SLVERR reporting.
module axi_sys_bridge #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int IW     = 4,
  parameter int LW     = 4,
  parameter int TO_CYC = 32
) (
  input  logic            aclk_i,
  input  logic            arst_i,
  // write address
  input  logic [AW-1:0]   awaddr_i,
  input  logic [IW-1:0]   awid_i,
  input  logic [LW-1:0]   awlen_i,
  input  logic [2:0]      awsize_i,
  input  logic            awvalid_i,
  output logic            awready_o,
  // write data
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic            wlast_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  // write response
  output logic [IW-1:0]   bid_o,
  output logic [1:0]      bresp_o,
  output logic            bvalid_o,
  input  logic            bready_i,
  // read address
  input  logic [AW-1:0]   araddr_i,
  input  logic [IW-1:0]   arid_i,
  input  logic [LW-1:0]   arlen_i,
  input  logic [2:0]      arsize_i,
  input  logic            arvalid_i,
  output logic            arready_o,
  // read data
  output logic [IW-1:0]   rid_o,
  output logic [DW-1:0]   rdata_o,
  output logic [1:0]      rresp_o,
  output logic            rlast_o,
  output logic            rvalid_o,
  input  logic            rready_i,
  // system bus
  output logic [AW-1:0]   sys_addr_o,
  output logic [DW-1:0]   sys_wdata_o,
  output logic [DW/8-1:0] sys_sel_o,
  output logic            sys_wen_o,
  output logic            sys_ren_o,
  input  logic [DW-1:0]   sys_rdata_i,
  input  logic            sys_err_i,
  input  logic            sys_ack_i
);

  localparam int SW     = DW / 8;
  localparam int SZ_MAX = $clog2(SW);
  localparam int CW     = $clog2(TO_CYC + 1);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_BUS,
    WR_DRAIN,
    WR_RESP,
    RD_BUS,
    RD_RESP
  } state_t;

  state_t        state_q;
  logic          idle_q;
  logic          wr_turn_q;
  logic [CW-1:0] to_cnt_q;

  logic both_req;
  logic aw_hs;
  logic ar_hs;
  logic w_hs;
  logic aw_ok;
  logic ar_ok;
  logic to_hit;

  // Only single-beat transfers no wider than the data bus reach the sys bus.
  function automatic logic xfer_ok(input logic [LW-1:0] len, input logic [2:0] size);
    return (len == '0) && (int'(size) <= SZ_MAX);
  endfunction

  assign aw_ok    = xfer_ok(awlen_i, awsize_i);
  assign ar_ok    = xfer_ok(arlen_i, arsize_i);
  assign both_req = awvalid_i && arvalid_i;

  // idle_q is low during and right after reset, so no handshake can occur there.
  assign awready_o = idle_q && !(both_req && !wr_turn_q);
  assign arready_o = idle_q && !(both_req && wr_turn_q);
  assign aw_hs     = awvalid_i && awready_o;
  assign ar_hs     = arvalid_i && arready_o;

  assign wready_o  = (state_q == WR_COLLECT) || (state_q == WR_DRAIN) || (aw_hs && aw_ok);
  assign w_hs      = wvalid_i && wready_o;

  assign to_hit    = (to_cnt_q == CW'(TO_CYC - 1));
  assign rlast_o   = rvalid_o;

  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      idle_q      <= 1'b0;
      wr_turn_q   <= 1'b1;
      to_cnt_q    <= '0;
      bid_o       <= '0;
      bresp_o     <= '0;
      bvalid_o    <= 1'b0;
      rid_o       <= '0;
      rdata_o     <= '0;
      rresp_o     <= '0;
      rvalid_o    <= 1'b0;
      sys_addr_o  <= '0;
      sys_wdata_o <= '0;
      sys_sel_o   <= '0;
      sys_wen_o   <= 1'b0;
      sys_ren_o   <= 1'b0;
    end else begin
      sys_wen_o <= 1'b0;
      sys_ren_o <= 1'b0;
      case (state_q)
        IDLE: begin
          idle_q   <= 1'b1;
          to_cnt_q <= '0;
          if (aw_hs) begin
            idle_q     <= 1'b0;
            wr_turn_q  <= 1'b0;
            bid_o      <= awid_i;
            sys_addr_o <= awaddr_i;
            if (!aw_ok) begin
              state_q <= WR_DRAIN;
            end else if (w_hs) begin
              sys_wdata_o <= wdata_i;
              sys_sel_o   <= wstrb_i;
              sys_wen_o   <= 1'b1;
              state_q     <= WR_BUS;
            end else begin
              state_q <= WR_COLLECT;
            end
          end else if (ar_hs) begin
            idle_q    <= 1'b0;
            wr_turn_q <= 1'b1;
            rid_o     <= arid_i;
            if (!ar_ok) begin
              rdata_o  <= '0;
              rresp_o  <= RESP_SLVERR;
              rvalid_o <= 1'b1;
              state_q  <= RD_RESP;
            end else begin
              sys_addr_o <= araddr_i;
              sys_sel_o  <= {SW{1'b1}};
              sys_ren_o  <= 1'b1;
              state_q    <= RD_BUS;
            end
          end
        end

        WR_COLLECT: begin
          if (w_hs) begin
            sys_wdata_o <= wdata_i;
            sys_sel_o   <= wstrb_i;
            sys_wen_o   <= 1'b1;
            state_q     <= WR_BUS;
          end
        end

        // An ack in the last counted cycle still wins over the timeout.
        WR_BUS: begin
          if (sys_ack_i) begin
            bresp_o  <= {sys_err_i, 1'b0};
            bvalid_o <= 1'b1;
            state_q  <= WR_RESP;
          end else if (to_hit) begin
            bresp_o  <= RESP_SLVERR;
            bvalid_o <= 1'b1;
            state_q  <= WR_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + CW'(1);
          end
        end

        WR_DRAIN: begin
          if (w_hs && wlast_i) begin
            bresp_o  <= RESP_SLVERR;
            bvalid_o <= 1'b1;
            state_q  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bready_i) begin
            bvalid_o <= 1'b0;
            idle_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end

        RD_BUS: begin
          if (sys_ack_i) begin
            rdata_o  <= sys_rdata_i;
            rresp_o  <= {sys_err_i, 1'b0};
            rvalid_o <= 1'b1;
            state_q  <= RD_RESP;
          end else if (to_hit) begin
            rdata_o  <= '0;
            rresp_o  <= RESP_SLVERR;
            rvalid_o <= 1'b1;
            state_q  <= RD_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + CW'(1);
          end
        end

        RD_RESP: begin
          if (rready_i) begin
            rvalid_o <= 1'b0;
            idle_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end

        default: begin
          idle_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_sys_bridge.md
Name: axi_sys_bridge

Overview:
Synthesizable single-beat AXI3/AXI4 slave that converts AXI read and write transactions into the Red Pitaya system register bus (sys_*). It sits directly downstream of the AXI master (the PS GP port, or the AXI master model in simulation) and upstream of the sys_bus register decoders. It serves one transaction at a time, handles bus timeouts, and reports errors via BRESP/RRESP.

Parameters:
AW, 32, address width.
DW, 32, data width; DW/8 strobe bits.
IW, 4, AXI ID width.
LW, 4, AXI length field width.
TO_CYC, 32, sys_ack timeout in aclk_i cycles (>=2).

Ports:
aclk_i  input  1  clock
arst_i  input  1  asynchronous reset, active high
awaddr_i/araddr_i  input  AW  write/read address
awid_i/arid_i  input  IW  write/read ID
awlen_i/arlen_i  input  LW  burst length-1 (only 0 is serviced)
awsize_i/arsize_i  input  3  beat size, log2 bytes
awvalid_i/arvalid_i  input  1  address valid
awready_o/arready_o  output  1  address ready
wdata_i  input  DW  write data
wstrb_i  input  DW/8  byte strobes
wlast_i  input  1  last write beat
wvalid_i  input  1  write data valid
wready_o  output  1  write data ready
bid_o/rid_o  output  IW  response ID (echo of captured awid/arid)
bresp_o/rresp_o  output  2  response: 00 OKAY, 10 SLVERR
bvalid_o/rvalid_o  output  1  response valid
bready_i/rready_i  input  1  response ready
rdata_o  output  DW  read data
rlast_o  output  1  asserted together with rvalid_o
sys_addr_o  output  AW  bus address
sys_wdata_o  output  DW  bus write data
sys_sel_o  output  DW/8  bus byte select (wstrb for writes, all ones for reads)
sys_wen_o  output  1  one-cycle write strobe
sys_ren_o  output  1  one-cycle read strobe
sys_rdata_i  input  DW  bus read data
sys_err_i  input  1  bus error, valid with sys_ack_i
sys_ack_i  input  1  bus access complete
Burst, cache, prot and lock sidebands are not ports; they are ignored.

Behaviour:
- Reset (async, arst_i=1): state IDLE; all ready, valid, wen and ren outputs 0; resp, ID, rdata, sys_addr, sys_wdata and sys_sel outputs 0; timeout counter 0. A mid-transaction reset abandons the transaction with no response.
- FSM states: IDLE, WR_COLLECT, WR_BUS, WR_DRAIN, WR_RESP, RD_BUS, RD_RESP.
- IDLE: awready_o=arready_o=1. A read is pending when arvalid_i=1; a write is pending when awvalid_i=1. If both are pending in the same cycle, round-robin applies: the kind not served last wins (write wins after reset). Only the winner's ready is held high that cycle; the other is deasserted.
- Write: capture awaddr, awid, awlen and awsize, then go to WR_COLLECT with wready_o=1. The W beat may arrive in the same cycle as AW (then capture both and skip WR_COLLECT) or any later cycle. W arriving before AW is not accepted: wready_o=0 in IDLE.
- Illegal write (awlen!=0, or 8*2^awsize>DW): no bus access. WR_DRAIN accepts beats until wlast_i handshake, then WR_RESP with bresp 10.
- WR_BUS: sys_wen_o pulses exactly one cycle (the first WR_BUS cycle), with sys_addr_o, sys_wdata_o and sys_sel_o held stable until ack/timeout. On sys_ack_i, bresp = {sys_err_i,1'b0}. If TO_CYC cycles elapse without ack, bresp=10.
- Read: capture in IDLE. If illegal, go directly to RD_RESP with rresp 10 and rdata 0. Otherwise RD_BUS: sys_ren_o pulses one cycle; on ack, latch sys_rdata_i and rresp={sys_err_i,0}. On timeout, rdata=0 and rresp=10.
- Response states: valid held until the ready handshake; ID, resp and data stable while valid; return to IDLE next cycle. Minimum latency from AW+W accepted to bvalid_o is 2 cycles with same-cycle ack.
- sys_ack_i outside WR_BUS/RD_BUS is ignored. A late ack after a timeout is ignored.

Test Plan:
- Write 0x40000010 data 0xDEADBEEF size 2 id 3, ack 1 cycle after wen -> one wen pulse, sys_sel_o=4'hF, bid_o=3, bresp_o=00.
- Read 0x40000014 id 5, sys_rdata_i=0x12345678 ack after 4 cycles -> rdata_o=0x12345678, rid_o=5, rresp_o=00, rlast_o=1.
- Simultaneous AW/W and AR after reset -> write served first, then read; alternation confirmed over 4 rounds.
- No ack with TO_CYC=32 -> bvalid_o at cycle 32 after wen, bresp_o=10; late ack ignored.
- awlen=3 burst -> 4 beats drained, no sys_wen_o, bresp_o=10. arsize=3 with DW=32 -> rresp_o=10, no sys_ren_o.
- bready_i held low 10 cycles, then assert arst_i mid-RD_BUS -> outputs hold, then all return to reset values asynchronously.
